// File: rtl/spi_cmd_rx.sv
// SPI mode-0 command receiver, oversampled in the pixel clock domain.
// Assembles fixed-length command packets from sck/sdi and presents them on a
// valid/ready port, while shifting a status byte back on sdo.
// Optional build macro: SPI_CMD_CHECKSUM_EN (adds a trailing XOR checksum byte
// per packet and a sticky chk_err output).
module spi_cmd_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [4:0]  STATUS_PAD  = 5'b10101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       ce,
  output logic       sdo,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_op,
  output logic [7:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic [7:0] cmd_data,
  output logic       overflow
`ifdef SPI_CMD_CHECKSUM_EN
  ,
  output logic       chk_err
`endif
);

`ifdef SPI_CMD_CHECKSUM_EN
  localparam int unsigned NumBytes = 5;
  localparam int unsigned ByteCntW = 3;
`else
  localparam int unsigned NumBytes = 4;
  localparam int unsigned ByteCntW = 2;
`endif

  typedef enum logic {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, ce_sync_q;
  logic                   sck_hist_q, ce_hist_q;
  logic                   sck_s, sdi_s, ce_s;
  logic                   sck_rise, sck_fall, ce_rise;
  logic                   frame_start, frame_end, in_frame;

  logic [2:0]          bit_cnt_q;
  logic [ByteCntW-1:0] byte_cnt_q;
  logic [7:0]          rx_shift_q, tx_shift_q;
  logic                sdo_q;
  logic [7:0]          stage_q [NumBytes-1];

  logic [7:0] rx_byte;
  logic       byte_done, pkt_done, chk_ok;
  logic [7:0] pkt_op, pkt_x, pkt_y, pkt_data;
  logic [7:0] status;

  logic       cmd_valid_q, cmd_valid_d;
  logic       overflow_q, overflow_d;
  logic       cmd_load;
  logic [7:0] cmd_op_q, cmd_x_q, cmd_y_q, cmd_data_q;
`ifdef SPI_CMD_CHECKSUM_EN
  logic       chk_err_q, chk_err_d;
`endif

  // Synchronizers on the async SPI pins plus edge-history flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      ce_sync_q  <= '0;
      sck_hist_q <= 1'b0;
      ce_hist_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      ce_sync_q  <= {ce_sync_q[SYNC_STAGES-2:0], ce};
      sck_hist_q <= sck_s;
      ce_hist_q  <= ce_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign ce_s     = ce_sync_q[SYNC_STAGES-1];
  assign ce_rise  = ce_s & ~ce_hist_q;
  assign sck_rise = in_frame & sck_s & ~sck_hist_q;
  assign sck_fall = in_frame & ~sck_s & sck_hist_q;

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Frame next-state: open on synchronized ce rise, close on ce low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ce_rise) state_d = StActive;
      StActive: if (!ce_s)   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Frame control strobes.
  always_comb begin
    frame_start = (state_q == StIdle) && ce_rise;
    frame_end   = (state_q == StActive) && !ce_s;
    in_frame    = (state_q == StActive) && ce_s;
  end

  assign rx_byte   = {rx_shift_q[6:0], sdi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign pkt_done  = byte_done && (byte_cnt_q == ByteCntW'(NumBytes - 1));

  assign pkt_op = stage_q[0];
  assign pkt_x  = stage_q[1];
  assign pkt_y  = stage_q[2];
`ifdef SPI_CMD_CHECKSUM_EN
  assign pkt_data = stage_q[3];
  assign chk_ok   = ((stage_q[0] ^ stage_q[1] ^ stage_q[2] ^ stage_q[3]) == rx_byte);
  assign status   = {cmd_valid_q, overflow_q, chk_err_q, STATUS_PAD};
`else
  // The last byte goes straight to the command register, never to staging.
  assign pkt_data = rx_byte;
  assign chk_ok   = 1'b1;
  assign status   = {cmd_valid_q, overflow_q, 1'b0, STATUS_PAD};
`endif

  // Bit/byte counters, rx/tx shifters, staging registers and sdo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      sdo_q      <= 1'b0;
      for (int i = 0; i < int'(NumBytes) - 1; i++) stage_q[i] <= '0;
    end else if (frame_start) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_shift_q <= status;
      sdo_q      <= status[7];
    end else if (frame_end) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_shift_q <= '0;
      sdo_q      <= 1'b0;
    end else begin
      if (sck_rise) begin
        rx_shift_q <= rx_byte;
        bit_cnt_q  <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        for (int i = 0; i < int'(NumBytes) - 1; i++) begin
          if (byte_cnt_q == ByteCntW'(i)) stage_q[i] <= rx_byte;
        end
        byte_cnt_q <= pkt_done ? '0 : byte_cnt_q + ByteCntW'(1);
      end
      // A wrapped bit count on a fall means the previous byte is finished:
      // refresh the status so every byte reports current state.
      if (sck_fall) begin
        if (bit_cnt_q == 3'd0) begin
          tx_shift_q <= status;
          sdo_q      <= status[7];
        end else begin
          tx_shift_q <= {tx_shift_q[6:0], 1'b0};
          sdo_q      <= tx_shift_q[6];
        end
      end
    end
  end

  // Packet completion and valid/ready handshake next-state.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    overflow_d  = overflow_q;
    cmd_load    = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
    chk_err_d   = chk_err_q;
`endif
    if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
    if (pkt_done) begin
      if (!chk_ok) begin
`ifdef SPI_CMD_CHECKSUM_EN
        chk_err_d = 1'b1;
`endif
      end else if (pkt_op == 8'hFF) begin
        overflow_d = 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
        chk_err_d  = 1'b0;
`endif
      end else if (!cmd_valid_q || cmd_ready) begin
        cmd_load    = 1'b1;
        cmd_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Command output registers; survive ce deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      cmd_op_q    <= '0;
      cmd_x_q     <= '0;
      cmd_y_q     <= '0;
      cmd_data_q  <= '0;
`ifdef SPI_CMD_CHECKSUM_EN
      chk_err_q   <= 1'b0;
`endif
    end else begin
      cmd_valid_q <= cmd_valid_d;
      overflow_q  <= overflow_d;
`ifdef SPI_CMD_CHECKSUM_EN
      chk_err_q   <= chk_err_d;
`endif
      if (cmd_load) begin
        cmd_op_q   <= pkt_op;
        cmd_x_q    <= pkt_x;
        cmd_y_q    <= pkt_y;
        cmd_data_q <= pkt_data;
      end
    end
  end

  assign sdo       = sdo_q;
  assign cmd_valid = cmd_valid_q;
  assign overflow  = overflow_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_x     = cmd_x_q;
  assign cmd_y     = cmd_y_q;
  assign cmd_data  = cmd_data_q;
`ifdef SPI_CMD_CHECKSUM_EN
  assign chk_err   = chk_err_q;
`endif

endmodule
